// File: rtl/write_phase_sequencer.sv
// DDR5 write-path phase sequencer: preamble, data, optional CRC, postamble, interamble and gap per burst.
// Optional CRC slot compiled in with `define WR_CRC_EN.
module write_phase_sequencer #(
  parameter int PRE_W  = 3,
  parameter int POST_W = 2,
  parameter int GAP_W  = 4,
  parameter int CNT_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_start,
  input  logic [PRE_W-1:0]  i_precycle,
  input  logic [POST_W-1:0] i_postcycle,
  input  logic [GAP_W-1:0]  i_gap,
  input  logic [1:0]        i_burstlength,
  input  logic              i_dram_crc_en,
  input  logic              i_phy_crc_mode,
  output logic [2:0]        o_state,
  output logic              o_dqs_en,
  output logic              o_preamble_load,
  output logic              o_data_req,
  output logic [CNT_W-1:0]  o_beat_cnt,
  output logic              o_last,
  output logic              o_crc_generate,
  output logic [CNT_W-1:0]  o_amble_cnt,
  output logic              o_start_err
);
  localparam int SUM_W = ((PRE_W > POST_W) ? PRE_W : POST_W) + 1;
  localparam int CMP_W = (GAP_W > SUM_W) ? GAP_W : SUM_W;
  localparam int LEN_W = (CMP_W > CNT_W) ? CMP_W : CNT_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PRE = 3'd1, S_DATA = 3'd2, S_CRC = 3'd3,
    S_POST = 3'd4, S_INTER = 3'd5, S_GAPW = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [PRE_W-1:0]   p_q, p_d;
  logic [POST_W-1:0]  q_q, q_d, qn_q, qn_d;
  logic [CNT_W-1:0]   d_q, d_d;
  logic               crc_q, crc_d, gen_q, gen_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CMP_W-1:0]   gapw_q, gapw_d;

  logic [PRE_W-1:0]   p_new;
  logic [POST_W-1:0]  q_new;
  logic [SUM_W-1:0]   sum;
  logic               last_now, accept;
  logic               dqs_d, pl_d, dreq_d, last_d, gen_out_d, err_d;
  logic [CNT_W-1:0]   beat_d, amble_d;

  function automatic logic [CNT_W-1:0] data_cycles(input logic [1:0] bl);
    case (bl)
      2'b01:   return CNT_W'(16);
      2'b10:   return CNT_W'(4);
      default: return CNT_W'(8);
    endcase
  endfunction

  function automatic logic at_end(input logic [CNT_W-1:0] cnt, input logic [LEN_W-1:0] len);
    return ({1'b0, LEN_W'(cnt)} + (LEN_W + 1)'(1)) == {1'b0, len};
  endfunction

`ifdef WR_CRC_EN
  logic crc_sel;
  assign crc_sel = i_dram_crc_en;
`else
  logic       crc_sel;
  logic [1:0] unused_crc;
  assign crc_sel    = 1'b0;
  assign unused_crc = {i_dram_crc_en, i_phy_crc_mode};
`endif

  always_comb begin
    p_new    = (i_precycle == '0) ? PRE_W'(1) : i_precycle;
    q_new    = (i_postcycle == '0) ? POST_W'(1) : i_postcycle;
    sum      = SUM_W'(q_q) + SUM_W'(p_new);
    last_now = ((state_q == S_DATA) && at_end(cnt_q, LEN_W'(d_q)) && !crc_q) || (state_q == S_CRC);
    accept   = i_wr_start && ((state_q == S_IDLE) || last_now);

    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    pend_d  = pend_q;
    p_d = p_q; q_d = q_q; qn_d = qn_q; d_d = d_q;
    crc_d = crc_q; gen_d = gen_q; gap_d = gap_q; gapw_d = gapw_q;

    if (accept) begin
      p_d    = p_new;
      qn_d   = q_new;
      d_d    = data_cycles(i_burstlength);
      crc_d  = crc_sel;
      gen_d  = i_phy_crc_mode;
      gap_d  = i_gap;
      gapw_d = CMP_W'(i_gap) - CMP_W'(sum);
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = S_PRE;
      end
      S_PRE: if (at_end(cnt_q, LEN_W'(p_q))) begin
        state_d = S_DATA; cnt_d = '0; q_d = qn_q;
      end
      S_INTER: if (at_end(cnt_q, LEN_W'(gap_q))) begin
        state_d = S_DATA; cnt_d = '0; q_d = qn_q;
      end
      S_GAPW: if (at_end(cnt_q, LEN_W'(gapw_q))) begin
        state_d = S_PRE; cnt_d = '0;
      end
      S_POST: if (at_end(cnt_q, LEN_W'(q_q))) begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (!pend_q)             state_d = S_IDLE;
        else if (gapw_q == '0)   state_d = S_PRE;
        else                     state_d = S_GAPW;
      end
      default: ;
    endcase

    // End of burst: either extend into the CRC slot or pick the follow-on phase
    if (state_q == S_DATA && at_end(cnt_q, LEN_W'(d_q)) && crc_q) begin
      state_d = S_CRC; cnt_d = '0;
    end else if (last_now) begin
      cnt_d = '0;
      if (!accept)                                   state_d = S_POST;
      else if (i_gap == '0)                          begin state_d = S_DATA; q_d = q_new; end
      else if (CMP_W'(i_gap) < CMP_W'(sum))          state_d = S_INTER;
      else                                           begin state_d = S_POST; pend_d = 1'b1; end
    end

    dqs_d     = (state_d == S_PRE) || (state_d == S_DATA) || (state_d == S_CRC) ||
                (state_d == S_POST) || (state_d == S_INTER);
    pl_d      = (state_d == S_PRE) && (cnt_d == '0);
    dreq_d    = (state_d == S_DATA);
    beat_d    = dreq_d ? cnt_d : '0;
    last_d    = ((state_d == S_DATA) && at_end(cnt_d, LEN_W'(d_d)) && !crc_d) || (state_d == S_CRC);
`ifdef WR_CRC_EN
    gen_out_d = (state_d == S_CRC) && gen_d;
`else
    gen_out_d = 1'b0;
`endif
    amble_d   = ((state_d == S_PRE) || (state_d == S_POST) || (state_d == S_INTER) ||
                 (state_d == S_GAPW)) ? cnt_d : '0;
    err_d     = i_wr_start && !accept;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      pend_q          <= 1'b0;
      o_dqs_en        <= 1'b0;
      o_preamble_load <= 1'b0;
      o_data_req      <= 1'b0;
      o_beat_cnt      <= '0;
      o_last          <= 1'b0;
      o_crc_generate  <= 1'b0;
      o_amble_cnt     <= '0;
      o_start_err     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pend_q          <= pend_d;
      o_dqs_en        <= dqs_d;
      o_preamble_load <= pl_d;
      o_data_req      <= dreq_d;
      o_beat_cnt      <= beat_d;
      o_last          <= last_d;
      o_crc_generate  <= gen_out_d;
      o_amble_cnt     <= amble_d;
      o_start_err     <= err_d;
    end
  end

  // Burst configuration only matters once a start is accepted, so it carries no reset
  always_ff @(posedge i_clk) begin
    p_q <= p_d; q_q <= q_d; qn_q <= qn_d; d_q <= d_d;
    crc_q <= crc_d; gen_q <= gen_d; gap_q <= gap_d; gapw_q <= gapw_d;
  end

  assign o_state = state_q;
endmodule
